alarm_setter: RTL and testbench

- User-input front end for the alarm clock: turns three raw board buttons into BCD time-set and alarm-set values for top_alarm.
- It is the other end of the alarm core's time interface. top_alarm consumes the init/alarm digits; this block produces them.
- It also reads back the running time, so an edit starts from the current time.
- Sits in the board top beside top_alarm. Its digits feed the init/alarm inputs; its cursor/edit flags drive display blinking.

---
 rtl/alarm_pkg.sv | 35 +++
 rtl/alarm_setter_btn_debounce.sv | 56 +++++
 rtl/alarm_setter.sv | 151 +++++++++++++++
 tb/tb_alarm_setter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types and BCD limits for the alarm-clock user-input front end.
package alarm_pkg;

   // Encodings double as the edit_active output value.
   typedef enum logic [1:0] {
      IDLE       = 2'b00,
      EDIT_TIME  = 2'b01,
      EDIT_ALARM = 2'b10
   } state_e;

   localparam logic [3:0] HOURDEC_MAX      = 4'd2;
   localparam logic [3:0] HOURONE_MAX_AT_2 = 4'd3;
   localparam logic [3:0] MINDEC_MAX       = 4'd5;
   localparam logic [3:0] DIGIT_MAX        = 4'd9;

   typedef struct packed {
      logic [3:0] hourdec;
      logic [3:0] hourone;
      logic [3:0] mindec;
      logic [3:0] minone;
   } time_t;

   // Replace any non-BCD or out-of-range digit with 0 so edits start legal.
   function automatic time_t sanitize(input time_t t);
      time_t r;
      r = t;
      if (r.hourdec > HOURDEC_MAX) r.hourdec = '0;
      if (r.hourone > DIGIT_MAX) r.hourone = '0;
      if (r.hourdec == HOURDEC_MAX && r.hourone > HOURONE_MAX_AT_2) r.hourone = '0;
      if (r.mindec > MINDEC_MAX) r.mindec = '0;
      if (r.minone > DIGIT_MAX) r.minone = '0;
      return r;
   endfunction

endpackage

// File: rtl/alarm_setter_btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter, one-cycle
// pulse on each accepted press (never on release).
module btn_debounce
   import alarm_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rstn,
   input  logic btn,
   output logic pulse
);

   localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

   logic          sync1_q, sync2_q;
   logic          level_q, level_d;
   logic          prev_q;
   logic          pulse_q;
   logic [CW-1:0] cnt_q, cnt_d;

   // Accept a new level only after DEB_CYCLES consecutive differing samples.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CW'(DEB_CYCLES - 1)) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Synchroniser, debounced level and registered rising-edge pulse.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         prev_q  <= 1'b0;
         pulse_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn;
         sync2_q <= sync1_q;
         level_q <= level_d;
         prev_q  <= level_q;
         pulse_q <= level_q & ~prev_q;
         cnt_q   <= cnt_d;
      end
   end

   assign pulse = pulse_q;

endmodule

// File: rtl/alarm_setter.sv
// Alarm-clock setter: debounced buttons drive a time/alarm BCD edit FSM.
module alarm_setter
   import alarm_pkg::*;
#(
   parameter int unsigned DEB_CYCLES     = 1_000_000,
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000_000
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        btn_mode,
   input  logic        btn_next,
   input  logic        btn_inc,
   input  logic [15:0] time_now,
   output logic [15:0] time_init,
   output logic        time_load,
   output logic [15:0] alarm_time,
   output logic        bud_en,
   output logic [1:0]  edit_active,
   output logic [3:0]  cursor
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   logic    p_mode, p_next, p_inc, any_p;

   state_e  state_q, state_d;
   time_t   buf_q, buf_d;
   time_t   init_q, init_d;
   time_t   alarm_q, alarm_d;
   logic [3:0]    cur_q, cur_d;
   logic          load_q, load_d;
   logic          bud_q, bud_d;
   logic [TW-1:0] tmo_q, tmo_d;

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
      .clk(clk), .rstn(rstn), .btn(btn_mode), .pulse(p_mode));
   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
      .clk(clk), .rstn(rstn), .btn(btn_next), .pulse(p_next));
   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
      .clk(clk), .rstn(rstn), .btn(btn_inc), .pulse(p_inc));

   assign any_p = p_mode | p_next | p_inc;

   // Increment the digit under the one-hot cursor with per-digit wrap, no carry.
   function automatic time_t bump(input time_t b, input logic [3:0] cur);
      time_t r;
      r = b;
      if (cur[3]) begin
         if (b.hourdec >= HOURDEC_MAX) begin
            r.hourdec = '0;
         end else begin
            r.hourdec = b.hourdec + 4'd1;
            if (r.hourdec == HOURDEC_MAX && b.hourone > HOURONE_MAX_AT_2) r.hourone = '0;
         end
      end else if (cur[2]) begin
         if (b.hourdec == HOURDEC_MAX) begin
            r.hourone = (b.hourone >= HOURONE_MAX_AT_2) ? 4'd0 : b.hourone + 4'd1;
         end else begin
            r.hourone = (b.hourone >= DIGIT_MAX) ? 4'd0 : b.hourone + 4'd1;
         end
      end else if (cur[1]) begin
         r.mindec = (b.mindec >= MINDEC_MAX) ? 4'd0 : b.mindec + 4'd1;
      end else if (cur[0]) begin
         r.minone = (b.minone >= DIGIT_MAX) ? 4'd0 : b.minone + 4'd1;
      end
      return r;
   endfunction

   // Next-state and commit logic; mode outranks next, next outranks inc.
   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      init_d  = init_q;
      alarm_d = alarm_q;
      cur_d   = cur_q;
      load_d  = 1'b0;
      bud_d   = bud_q;
      tmo_d   = '0;
      unique case (state_q)
         IDLE: begin
            if (p_mode) begin
               state_d = EDIT_TIME;
               buf_d   = sanitize(time_t'(time_now));
               cur_d   = 4'b1000;
            end else if (p_next) begin
               // ignored
            end else if (p_inc) begin
               bud_d = ~bud_q;
            end
         end
         EDIT_TIME, EDIT_ALARM: begin
            tmo_d = any_p ? '0 : tmo_q + 1'b1;
            if (p_mode || (!any_p && tmo_q == TW'(TIMEOUT_CYCLES - 1))) begin
               state_d = IDLE;
               cur_d   = '0;
            end else if (p_next) begin
               if (cur_q != 4'b0001) begin
                  cur_d = cur_q >> 1;
               end else if (state_q == EDIT_TIME) begin
                  init_d  = buf_q;
                  load_d  = 1'b1;
                  state_d = EDIT_ALARM;
                  buf_d   = sanitize(alarm_q);
                  cur_d   = 4'b1000;
               end else begin
                  alarm_d = buf_q;
                  state_d = IDLE;
                  cur_d   = '0;
               end
            end else if (p_inc) begin
               buf_d = bump(buf_q, cur_q);
            end
         end
         default: begin
            state_d = IDLE;
            cur_d   = '0;
         end
      endcase
   end

   // FSM, edit buffer and committed settings.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         buf_q   <= '0;
         init_q  <= '0;
         alarm_q <= '0;
         cur_q   <= '0;
         load_q  <= 1'b0;
         bud_q   <= 1'b0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         init_q  <= init_d;
         alarm_q <= alarm_d;
         cur_q   <= cur_d;
         load_q  <= load_d;
         bud_q   <= bud_d;
         tmo_q   <= tmo_d;
      end
   end

   assign time_init   = init_q;
   assign time_load   = load_q;
   assign alarm_time  = alarm_q;
   assign bud_en      = bud_q;
   assign edit_active = state_q;
   assign cursor      = cur_q;

endmodule

// File: tb/tb_alarm_setter.sv
// Self-checking bench for alarm_setter with short debounce/timeout.
module tb_alarm_setter;

   localparam int DEB = 4;
   localparam int TMO = 200;
   localparam int B_NONE = 0, B_MODE = 1, B_NEXT = 2, B_INC = 3;

   logic        clk = 1'b0;
   logic        rstn;
   logic        btn_mode, btn_next, btn_inc;
   logic [15:0] time_now;
   logic [15:0] time_init, alarm_time;
   logic        time_load, bud_en;
   logic [1:0]  edit_active;
   logic [3:0]  cursor;

   int compared = 0;
   int mismatched = 0;
   int loads = 0;
   int wide_loads = 0;
   logic prev_tl = 1'b0;

   alarm_setter #(.DEB_CYCLES(DEB), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rstn(rstn), .btn_mode(btn_mode), .btn_next(btn_next),
      .btn_inc(btn_inc), .time_now(time_now), .time_init(time_init),
      .time_load(time_load), .alarm_time(alarm_time), .bud_en(bud_en),
      .edit_active(edit_active), .cursor(cursor));

   always #5 clk = ~clk;

   // Count time_load strobes and catch any strobe lasting more than one cycle.
   always @(negedge clk) begin
      if (time_load) loads++;
      if (time_load && prev_tl) wide_loads++;
      prev_tl = time_load;
   end

   typedef struct {
      int          btn;
      logic [15:0] tnow;
      logic [1:0]  ed;
      logic [3:0]  cur;
      logic [15:0] ti;
      logic [15:0] at;
      logic        be;
      int          nloads;
   } vec_t;

   vec_t vt[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_btn(input int b, input logic v);
      if (b == B_MODE) btn_mode = v;
      if (b == B_NEXT) btn_next = v;
      if (b == B_INC)  btn_inc  = v;
   endtask

   task automatic press(input int b);
      @(posedge clk); #1;
      set_btn(b, 1'b1);
      repeat (DEB + 8) @(posedge clk);
      #1 set_btn(b, 1'b0);
      repeat (DEB + 8) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_all(input string tag, input logic [1:0] ed, input logic [3:0] cur,
                          input logic [15:0] ti, input logic [15:0] at, input logic be,
                          input int nl);
      chk({tag, ".edit_active"}, 32'(edit_active), 32'(ed));
      chk({tag, ".cursor"}, 32'(cursor), 32'(cur));
      chk({tag, ".time_init"}, 32'(time_init), 32'(ti));
      chk({tag, ".alarm_time"}, 32'(alarm_time), 32'(at));
      chk({tag, ".bud_en"}, 32'(bud_en), 32'(be));
      chk({tag, ".loads"}, 32'(loads), 32'(nl));
   endtask

   initial begin
      int n;
      rstn = 1'b0; btn_mode = 1'b0; btn_next = 1'b0; btn_inc = 1'b0;
      time_now = 16'h0000;

      // Main edit walk: time 15:59 -> hourdec 1->2 forces hourone 5->0 -> 20:59,
      // then alarm 00:00 -> 04:00, then an out-of-range time_now is sanitised.
      vt.push_back('{B_INC,  16'h1559, 2'b00, 4'b0000, 16'h0000, 16'h0000, 1'b1, 0});
      vt.push_back('{B_MODE, 16'h1559, 2'b01, 4'b1000, 16'h0000, 16'h0000, 1'b1, 0});
      vt.push_back('{B_INC,  16'h1559, 2'b01, 4'b1000, 16'h0000, 16'h0000, 1'b1, 0});
      vt.push_back('{B_NEXT, 16'h1559, 2'b01, 4'b0100, 16'h0000, 16'h0000, 1'b1, 0});
      vt.push_back('{B_NEXT, 16'h1559, 2'b01, 4'b0010, 16'h0000, 16'h0000, 1'b1, 0});
      vt.push_back('{B_NEXT, 16'h1559, 2'b01, 4'b0001, 16'h0000, 16'h0000, 1'b1, 0});
      vt.push_back('{B_NEXT, 16'h1559, 2'b10, 4'b1000, 16'h2059, 16'h0000, 1'b1, 1});
      for (int i = 0; i < 3; i++)
         vt.push_back('{B_INC, 16'h1559, 2'b10, 4'b1000, 16'h2059, 16'h0000, 1'b1, 1});
      vt.push_back('{B_NEXT, 16'h1559, 2'b10, 4'b0100, 16'h2059, 16'h0000, 1'b1, 1});
      for (int i = 0; i < 4; i++)
         vt.push_back('{B_INC, 16'h1559, 2'b10, 4'b0100, 16'h2059, 16'h0000, 1'b1, 1});
      vt.push_back('{B_NEXT, 16'h1559, 2'b10, 4'b0010, 16'h2059, 16'h0000, 1'b1, 1});
      for (int i = 0; i < 6; i++)
         vt.push_back('{B_INC, 16'h1559, 2'b10, 4'b0010, 16'h2059, 16'h0000, 1'b1, 1});
      vt.push_back('{B_NEXT, 16'h1559, 2'b10, 4'b0001, 16'h2059, 16'h0000, 1'b1, 1});
      vt.push_back('{B_NEXT, 16'h1559, 2'b00, 4'b0000, 16'h2059, 16'h0400, 1'b1, 1});
      vt.push_back('{B_MODE, 16'h2975, 2'b01, 4'b1000, 16'h2059, 16'h0400, 1'b1, 1});
      vt.push_back('{B_NEXT, 16'h2975, 2'b01, 4'b0100, 16'h2059, 16'h0400, 1'b1, 1});
      vt.push_back('{B_NEXT, 16'h2975, 2'b01, 4'b0010, 16'h2059, 16'h0400, 1'b1, 1});
      vt.push_back('{B_NEXT, 16'h2975, 2'b01, 4'b0001, 16'h2059, 16'h0400, 1'b1, 1});
      vt.push_back('{B_NEXT, 16'h2975, 2'b10, 4'b1000, 16'h2005, 16'h0400, 1'b1, 2});
      vt.push_back('{B_MODE, 16'h2975, 2'b00, 4'b0000, 16'h2005, 16'h0400, 1'b1, 2});

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_all("reset", 2'b00, 4'b0000, 16'h0000, 16'h0000, 1'b0, 0);
      chk("reset.time_load", 32'(time_load), 32'd0);
      rstn = 1'b1;
      repeat (2) @(posedge clk);

      // Glitches shorter than DEB_CYCLES are rejected
      @(posedge clk); #1 btn_inc = 1'b1;
      @(posedge clk); #1 btn_inc = 1'b0;
      repeat (10) @(posedge clk);
      #1 btn_inc = 1'b1;
      repeat (DEB - 1) @(posedge clk);
      #1 btn_inc = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("glitch.bud_en", 32'(bud_en), 32'd0);

      // Latency: pulse DEB+3 edges after raw rises, bud_en updates one edge later
      @(posedge clk); #1 btn_inc = 1'b1;
      n = 0;
      while (bud_en == 1'b0 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("latency.edges", 32'(n), 32'(DEB + 4));
      // Continue holding: total ~100 cycles high must not toggle again
      repeat (100 - n) @(posedge clk);
      #1 btn_inc = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("hold1.bud_en", 32'(bud_en), 32'd1);

      // Second long hold from a fresh press toggles back exactly once
      @(posedge clk); #1 btn_inc = 1'b1;
      repeat (100) @(posedge clk);
      #1 btn_inc = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("hold2.bud_en", 32'(bud_en), 32'd0);

      // Table-driven edit walk
      for (int i = 0; i < vt.size(); i++) begin
         time_now = vt[i].tnow;
         press(vt[i].btn);
         chk_all($sformatf("vec%0d", i), vt[i].ed, vt[i].cur, vt[i].ti, vt[i].at,
                 vt[i].be, vt[i].nloads);
      end

      // Abort with mode: nothing committed
      time_now = 16'h1234;
      press(B_MODE);
      press(B_INC);
      press(B_INC);
      press(B_MODE);
      chk_all("abort", 2'b00, 4'b0000, 16'h2005, 16'h0400, 1'b1, 2);

      // Timeout abort
      press(B_MODE);
      chk("tmo.entered", 32'(edit_active), 32'd1);
      repeat (TMO + 50) @(posedge clk);
      @(negedge clk);
      chk_all("timeout", 2'b00, 4'b0000, 16'h2005, 16'h0400, 1'b1, 2);

      // Mode and inc pulses in the same cycle: mode wins, bud_en untouched
      @(posedge clk); #1 btn_mode = 1'b1; btn_inc = 1'b1;
      repeat (DEB + 8) @(posedge clk);
      #1 btn_mode = 1'b0; btn_inc = 1'b0;
      repeat (DEB + 8) @(posedge clk);
      @(negedge clk);
      chk_all("same_cycle", 2'b01, 4'b1000, 16'h2005, 16'h0400, 1'b1, 2);
      press(B_MODE);
      chk("same_cycle.exit", 32'(edit_active), 32'd0);

      // Reset mid-edit with cursor on mindec
      press(B_MODE);
      press(B_NEXT);
      press(B_NEXT);
      chk("midrst.cursor", 32'(cursor), 32'b0010);
      #2 rstn = 1'b0;
      #1;
      chk_all("midrst", 2'b00, 4'b0000, 16'h0000, 16'h0000, 1'b0, 2);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("midrst.time_load", 32'(time_load), 32'd0);
      rstn = 1'b1;
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk_all("post_rst", 2'b00, 4'b0000, 16'h0000, 16'h0000, 1'b0, 2);
      chk("wide_loads", 32'(wide_loads), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
